// File: rtl/spi_router_pkg.sv
// rtl/spi_router_pkg.sv - opcode fields, FSM encodings and widths shared by spi_cmd_router
package spi_router_pkg;

    localparam int TX_W = 24;
    localparam int RX_W = 32;

    // Opcode byte is rd_data[7:0]: upper nibble picks the target, lower nibble rides along
    localparam int         OP_TGT_HI = 7;
    localparam int         OP_TGT_LO = 4;
    localparam int         OP_SUB_HI = 3;
    localparam int         OP_SUB_LO = 0;
    localparam logic [7:0] OP_NOP    = 8'h00;

    typedef enum logic {
        RX_IDLE,
        RX_DISPATCH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    // Width of a target index / round-robin pointer
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr wins
//   req   : per-target request
//   ptr   : highest-priority index this round
//   grant : one-hot grant (all zero when no request)
module rr_arbiter
    import spi_router_pkg::*;
#(
    parameter int NUM_TGT = 4,
    parameter int PW      = ptr_w(NUM_TGT)
)
(
    input  logic [NUM_TGT-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_TGT-1:0] grant
);

    logic [NUM_TGT-1:0]   rot;
    logic [NUM_TGT-1:0]   rot_gnt;
    logic [2*NUM_TGT-1:0] dbl_gnt;

    // Rotate so that index ptr sits at bit 0, isolate the lowest set bit,
    // then rotate back; the upper half of the doubled vector holds the wrap.
    assign rot     = NUM_TGT'({req, req} >> ptr);
    assign rot_gnt = rot & (~rot + NUM_TGT'(1));
    assign dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    assign grant   = dbl_gnt[2*NUM_TGT-1:NUM_TGT];

endmodule

// File: rtl/spi_cmd_router.sv
// rtl/spi_cmd_router.sv - routes SPI command words to targets and shares the SPI TX channel
//   rd_data_available/rd_data/rd_ack : received words from spi_slave
//   wr_buffer_free/wr_en/wr_data     : transmit words to spi_slave
//   cmd_valid/cmd_ready/cmd_data     : one-hot command port to the targets
//   rsp_valid/rsp_data/rsp_last/rsp_ready : per-target response ports
//   err_cnt                          : saturating count of words with an unmapped target
module spi_cmd_router
    import spi_router_pkg::*;
#(
    parameter int NUM_TGT = 4,
    parameter int ERR_W   = 8
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rd_data_available,
    input  logic [RX_W-1:0]         rd_data,
    output logic                    rd_ack,
    input  logic                    wr_buffer_free,
    output logic                    wr_en,
    output logic [TX_W-1:0]         wr_data,
    output logic [NUM_TGT-1:0]      cmd_valid,
    input  logic [NUM_TGT-1:0]      cmd_ready,
    output logic [RX_W-1:0]         cmd_data,
    input  logic [NUM_TGT-1:0]      rsp_valid,
    input  logic [TX_W*NUM_TGT-1:0] rsp_data,
    input  logic [NUM_TGT-1:0]      rsp_last,
    output logic [NUM_TGT-1:0]      rsp_ready,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int PW = ptr_w(NUM_TGT);

    // ---------------- RX path ----------------
    rx_state_t                      rx_state;
    logic                           rda_q;
    logic                           rx_pend;
    logic                           rise;
    logic                           capture;
    logic [OP_TGT_HI-OP_TGT_LO:0]   tgt;

    assign rise    = rd_data_available & ~rda_q;
    // A fresh edge is taken straight away when idle; otherwise it waits in rx_pend
    assign capture = (rx_state == RX_IDLE) & (rx_pend | rise);
    assign tgt     = rd_data[OP_TGT_HI:OP_TGT_LO];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            rda_q     <= 1'b0;
            rx_pend   <= 1'b0;
            rd_ack    <= 1'b0;
            cmd_valid <= '0;
            cmd_data  <= '0;
            err_cnt   <= '0;
        end else begin
            rda_q   <= rd_data_available;
            rd_ack  <= capture;
            // Keep a second edge that lands in the same cycle a pended one is consumed
            rx_pend <= capture ? (rx_pend & rise) : (rx_pend | rise);
            case (rx_state)
                RX_IDLE: begin
                    if (capture && rd_data[OP_TGT_HI:OP_SUB_LO] != OP_NOP) begin
                        if (int'(tgt) >= NUM_TGT) begin
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ERR_W'(1);
                        end else begin
                            cmd_valid <= NUM_TGT'(1) << tgt;
                            cmd_data  <= rd_data;
                            rx_state  <= RX_DISPATCH;
                        end
                    end
                end
                RX_DISPATCH: begin
                    if ((cmd_valid & cmd_ready) != '0) begin
                        cmd_valid <= '0;
                        rx_state  <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- TX path ----------------
    tx_state_t          tx_state;
    logic [PW-1:0]      p;
    logic [PW-1:0]      g_idx;
    logic               last_q;
    logic [NUM_TGT-1:0] arb_grant;
    logic [PW-1:0]      arb_idx;
    logic               sel_valid;
    logic               sel_last;
    logic [TX_W-1:0]    sel_data;

    rr_arbiter #(
        .NUM_TGT (NUM_TGT),
        .PW      (PW)
    ) u_arb (
        .req   (rsp_valid),
        .ptr   (p),
        .grant (arb_grant)
    );

    always_comb begin
        arb_idx   = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (arb_grant[i])
                arb_idx = PW'(i);
            if (g_idx == PW'(i)) begin
                sel_valid = rsp_valid[i];
                sel_last  = rsp_last[i];
                sel_data  = rsp_data[i*TX_W +: TX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state  <= TX_IDLE;
            p         <= '0;
            g_idx     <= '0;
            last_q    <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            rsp_ready <= '0;
        end else begin
            wr_en     <= 1'b0;
            rsp_ready <= '0;
            case (tx_state)
                TX_IDLE: begin
                    if (rsp_valid != '0) begin
                        g_idx    <= arb_idx;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (sel_valid && wr_buffer_free) begin
                        wr_en     <= 1'b1;
                        wr_data   <= sel_data;
                        rsp_ready <= NUM_TGT'(1) << g_idx;
                        last_q    <= sel_last;
                        tx_state  <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    // wr_buffer_free still reflects the pre-write state this cycle
                    if (last_q) begin
                        p        <= (g_idx == PW'(NUM_TGT-1)) ? '0 : g_idx + PW'(1);
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_state <= TX_SEND;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_router.sv
// tb/tb_spi_cmd_router.sv - scoreboard bench for spi_cmd_router
module tb_spi_cmd_router;

    localparam int NT = 4;
    localparam int EW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            rd_data_available = 1'b0;
    logic [31:0]     rd_data = '0;
    logic            rd_ack;
    logic            wr_buffer_free = 1'b1;
    logic            wr_en;
    logic [23:0]     wr_data;
    logic [NT-1:0]   cmd_valid;
    logic [NT-1:0]   cmd_ready = '0;
    logic [31:0]     cmd_data;
    logic [NT-1:0]   rsp_valid;
    logic [24*NT-1:0] rsp_data;
    logic [NT-1:0]   rsp_last;
    logic [NT-1:0]   rsp_ready;
    logic [EW-1:0]   err_cnt;

    always #5 clk = ~clk;

    spi_cmd_router #(.NUM_TGT(NT), .ERR_W(EW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rd_data_available (rd_data_available),
        .rd_data           (rd_data),
        .rd_ack            (rd_ack),
        .wr_buffer_free    (wr_buffer_free),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .rsp_ready         (rsp_ready),
        .err_cnt           (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;

    logic [23:0] exp_tx[$];
    logic [35:0] exp_cmd[$];

    // Target response FIFOs: tail written by stimulus, head advanced by the target model
    logic [24:0] tmem [NT][32];
    int          thead [NT];
    int          ttail [NT];
    logic        prev_wr_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_last  = '0;
        for (int k = 0; k < NT; k++) begin
            if (thead[k] != ttail[k]) begin
                rsp_valid[k]          = 1'b1;
                rsp_data[k*24 +: 24]  = tmem[k][thead[k] % 32][23:0];
                rsp_last[k]           = tmem[k][thead[k] % 32][24];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NT; k++) begin
            if (!reset_n)
                thead[k] = ttail[k];
            else if (rsp_ready[k] && thead[k] != ttail[k])
                thead[k] = thead[k] + 1;
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] e_tx;
        logic [35:0] e_cmd;
        if (reset_n) begin
            if (rd_ack)
                n_ack++;
            if (wr_en) begin
                check("wr_en_gap", {31'b0, prev_wr_en}, 32'd0);
                e_tx = (exp_tx.size() > 0) ? {8'h0, exp_tx.pop_front()} : 32'hDEADBEEF;
                check("tx_data", {8'h0, wr_data}, e_tx);
            end
            if (rsp_ready != '0)
                check("rsp_ready_wr_en", {31'b0, wr_en}, 32'd1);
            if ((cmd_valid & cmd_ready) != '0) begin
                e_cmd = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 36'hF_FFFF_FFFF;
                check("cmd_valid", {28'b0, cmd_valid}, {28'b0, e_cmd[35:32]});
                check("cmd_data", cmd_data, e_cmd[31:0]);
            end
            prev_wr_en = wr_en;
        end else begin
            prev_wr_en = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input int k, input logic [23:0] d, input logic last);
        tmem[k][ttail[k] % 32] = {last, d};
        ttail[k] = ttail[k] + 1;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic got;
        got = 1'b0;
        tick();
        rd_data = w;
        rd_data_available = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = rd_ack;
        end
        check("rd_ack_seen", {31'b0, got}, 32'd1);
        rd_data_available = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int max);
        for (int i = 0; i < max && exp_tx.size() != 0; i++)
            tick();
        check(tag, exp_tx.size(), 32'd0);
    endtask

    task automatic wait_cmd(input string tag, input int max);
        for (int i = 0; i < max && exp_cmd.size() != 0; i++)
            tick();
        check(tag, exp_cmd.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic        got;
        int          a0;

        // Reset
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", {14'b0, wr_en, rd_ack, cmd_valid, rsp_ready, err_cnt}, 32'd0);
        check("rst_wr_data", {8'h0, wr_data}, 32'd0);
        check("rst_cmd_data", cmd_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single command to target 2, held until ready
        a0 = n_ack;
        exp_cmd.push_back({4'b0100, 32'hABCDEF21});
        send_word(32'hABCDEF21);
        check("r1_valid", {28'b0, cmd_valid}, 32'h4);
        check("r1_data", cmd_data, 32'hABCDEF21);
        repeat (5) begin
            tick();
            check("r1_hold_v", {28'b0, cmd_valid}, 32'h4);
            check("r1_hold_d", cmd_data, 32'hABCDEF21);
        end
        cmd_ready = 4'b0100;
        tick();
        cmd_ready = '0;
        check("r1_clear", {28'b0, cmd_valid}, 32'd0);
        check("r1_acks", n_ack - a0, 32'd1);
        check("r1_cmdq", exp_cmd.size(), 32'd0);

        // NOP and illegal target
        a0 = n_ack;
        send_word(32'h00000000);
        send_word(32'h12345671);
        tick();
        check("r2_acks", n_ack - a0, 32'd2);
        check("r2_err", {24'b0, err_cnt}, 32'd1);
        check("r2_no_cmd", {28'b0, cmd_valid}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            w[31:8] = 24'($urandom);
            w[7:4]  = 4'($urandom_range(4, 15));
            w[3:0]  = 4'($urandom);
            send_word(w);
            if (i == 252) begin
                tick();
                check("r2_err_254", {24'b0, err_cnt}, 32'd254);
            end
        end
        tick();
        check("r2_err_sat", {24'b0, err_cnt}, 32'd255);

        // Edge arriving during dispatch is pended
        exp_cmd.push_back({4'b0010, 32'hCAFE0010});
        send_word(32'hCAFE0010);
        exp_cmd.push_back({4'b1000, 32'h5555553A});
        tick();
        rd_data = 32'h5555553A;
        rd_data_available = 1'b1;
        a0 = n_ack;
        repeat (4) tick();
        check("r3_pended", n_ack - a0, 32'd0);
        check("r3_still", {28'b0, cmd_valid}, 32'h2);
        cmd_ready = 4'b1111;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = rd_ack;
        end
        check("r3_ack2", {31'b0, got}, 32'd1);
        rd_data_available = 1'b0;
        wait_cmd("r3_drain", 8);
        cmd_ready = '0;
        check("r3_acks", n_ack - a0, 32'd1);

        // Two single-word responses, p starts at 0
        push_rsp(0, 24'h111111, 1'b1);
        push_rsp(1, 24'h222222, 1'b1);
        exp_tx.push_back(24'h111111);
        exp_tx.push_back(24'h222222);
        wait_tx("t1_drain", 30);

        // p is now 2: target 3 beats target 0
        tick();
        push_rsp(3, 24'h333333, 1'b1);
        push_rsp(0, 24'h444444, 1'b1);
        exp_tx.push_back(24'h333333);
        exp_tx.push_back(24'h444444);
        wait_tx("t2_drain", 30);

        // p is now 1: burst from target 1 stays contiguous ahead of target 0
        tick();
        for (int i = 1; i <= 4; i++) begin
            push_rsp(1, 24'hB00000 + 24'(i), (i == 4));
            exp_tx.push_back(24'hB00000 + 24'(i));
        end
        push_rsp(0, 24'h0A0A0A, 1'b1);
        exp_tx.push_back(24'h0A0A0A);
        wait_tx("t3_drain", 60);

        // TX buffer busy
        tick();
        wr_buffer_free = 1'b0;
        push_rsp(2, 24'h555555, 1'b1);
        exp_tx.push_back(24'h555555);
        repeat (20) begin
            tick();
            check("t4_held", {31'b0, wr_en}, 32'd0);
        end
        wr_buffer_free = 1'b1;
        wait_tx("t4_free", 3);

        // Reset mid-burst and mid-dispatch
        send_word(32'h00BEEF20);
        check("t5_dispatch", {28'b0, cmd_valid}, 32'h4);
        for (int i = 1; i <= 4; i++)
            push_rsp(1, 24'hC00000 + 24'(i), (i == 4));
        exp_tx.push_back(24'hC00001);
        exp_tx.push_back(24'hC00002);
        wait_tx("t5_two", 40);
        reset_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {14'b0, wr_en, rd_ack, cmd_valid, rsp_ready, err_cnt}, 32'd0);
        check("t5_rst_wr_data", {8'h0, wr_data}, 32'd0);
        check("t5_rst_cmd_data", cmd_data, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        push_rsp(3, 24'h777777, 1'b1);
        push_rsp(0, 24'h666666, 1'b1);
        exp_tx.push_back(24'h666666);
        exp_tx.push_back(24'h777777);
        wait_tx("t5_p0", 30);
        cmd_ready = 4'b1111;
        exp_cmd.push_back({4'b0001, 32'h00000001});
        send_word(32'h00000001);
        wait_cmd("t5_rx", 8);
        cmd_ready = '0;

        repeat (4) tick();
        check("end_txq", exp_tx.size(), 32'd0);
        check("end_cmdq", exp_cmd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
